// File: rtl/blk_2f4dbe.sv
// blk_2f4dbe: eight-channel request arbiter with a registered, encoded grant.
//
// Configuration macro: LOGIC_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration. A 3-bit pointer holds the
//                highest-priority channel for the next arbitration.
//   undefined -> fixed priority. The lowest-index requester wins and no
//                pointer is built.
//
// grant[3] is the valid bit and grant[2:0] is the winning channel index.
// Latency is one clock. There is no combinational path from ID* to grant.
module blk_2f4dbe (
  input  logic       clk,
  input  logic       rst,
  input  logic       ID0,
  input  logic       ID1,
  input  logic       ID2,
  input  logic       ID3,
  input  logic       ID4,
  input  logic       ID5,
  input  logic       ID6,
  input  logic       ID7,
  output logic [3:0] grant
);

  // Search req starting at channel 'start' and wrapping modulo 8.
  // The loop runs from the farthest offset down to offset 0, so the last
  // assignment made is the nearest requester; it therefore wins.
  // Returns {found, index}, or 4'b0000 when nothing is requesting.
  function automatic logic [3:0] f_pick(input logic [7:0] req,
                                        input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  logic [7:0] w_req;
  logic [3:0] w_pick;
  logic [3:0] r_grant_p1;

  assign w_req = {ID7, ID6, ID5, ID4, ID3, ID2, ID1, ID0};

`ifdef LOGIC_ROUND_ROBIN_EN
  logic [2:0] r_ptr;

  // Stage p0 -> p1: the round-robin search starts at the pointer.
  always_comb begin
    w_pick = f_pick(w_req, r_ptr);
  end

  // Register the grant. The pointer moves past the winner and holds
  // through idle cycles. Reset clears all fairness history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_p1 <= 4'b0000;
      r_ptr      <= 3'd0;
    end else begin
      r_grant_p1 <= w_pick;
      if (w_pick[3]) begin
        r_ptr <= w_pick[2:0] + 3'd1;
      end
    end
  end
`else
  // Stage p0 -> p1: fixed priority. The search always starts at channel 0.
  always_comb begin
    w_pick = f_pick(w_req, 3'd0);
  end

  // Register the grant. Reset overrides any request present that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_p1 <= 4'b0000;
    end else begin
      r_grant_p1 <= w_pick;
    end
  end
`endif

  assign grant = r_grant_p1;

endmodule

// File: tb/tb_blk_2f4dbe.sv
// Testbench for blk_2f4dbe.
// It runs directed scenarios first, then randomized requests with occasional
// resets. Every cycle is also tracked by a behavioural model of the arbiter.
// Expected values follow LOGIC_ROUND_ROBIN_EN in the same way as the design.
module tb_blk_2f4dbe;

  logic       clk;
  logic       rst;
  logic       ID0, ID1, ID2, ID3, ID4, ID5, ID6, ID7;
  logic [3:0] grant;

  int n_total = 0;
  int n_bad   = 0;

  // Model state: the next channel to favour, and the expected grant.
  int         m_next = 0;
  logic [3:0] m_grant = 4'b0000;

  blk_2f4dbe dut (
    .clk  (clk),
    .rst  (rst),
    .ID0  (ID0),
    .ID1  (ID1),
    .ID2  (ID2),
    .ID3  (ID3),
    .ID4  (ID4),
    .ID5  (ID5),
    .ID6  (ID6),
    .ID7  (ID7),
    .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [3:0] got,
                           input logic [3:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b expected=%b", tag, got, exp);
    end
  endtask

  // Model: the first requesting channel in circular order from m_next
  // (from 0 in the fixed-priority build) becomes the owner.
  task automatic model_edge(input logic [7:0] req, input logic r);
    int start;
    int c;
    bit found;
    if (r) begin
      m_grant = 4'b0000;
      m_next  = 0;
    end else begin
`ifdef LOGIC_ROUND_ROBIN_EN
      start = m_next;
`else
      start = 0;
`endif
      found = 0;
      for (int k = 0; k < 8; k++) begin
        c = (start + k) % 8;
        if (!found && req[c]) begin
          found   = 1;
          m_grant = {1'b1, 3'(c)};
          m_next  = (c + 1) % 8;
        end
      end
      if (!found) m_grant = 4'b0000;
    end
  endtask

  // Drive inputs at the falling edge, let the rising edge occur, then
  // settle 1 time unit past it so outputs are sampled away from the edge.
  task automatic step(input logic [7:0] req, input logic r);
    @(negedge clk);
    {ID7, ID6, ID5, ID4, ID3, ID2, ID1, ID0} = req;
    rst = r;
    @(posedge clk);
    model_edge(req, r);
    #1;
  endtask

  initial begin
    logic [7:0] rq;
    rst = 1'b1;
    {ID7, ID6, ID5, ID4, ID3, ID2, ID1, ID0} = 8'h00;

    // Reset overrides requests, then a lone ID0 is granted.
    step(8'hFF, 1'b1);
    check_val("reset_all_req", grant, 4'b0000);
    step(8'h01, 1'b0);
    check_val("first_after_reset", grant, 4'b1000);

    // Two-way contention, an idle cycle, then contention again.
    step(8'h00, 1'b1);
    step(8'h90, 1'b0);
    check_val("contend_7_4", grant, 4'b1100);
    step(8'h0C, 1'b0);
    check_val("contend_3_2_wrap", grant, 4'b1010);
    step(8'h00, 1'b0);
    check_val("idle", grant, 4'b0000);
    step(8'h0C, 1'b0);
`ifdef LOGIC_ROUND_ROBIN_EN
    check_val("ptr_kept_idle", grant, 4'b1011);
`else
    check_val("ptr_kept_idle", grant, 4'b1010);
`endif

    // All eight channels requesting for 9 cycles after reset.
    step(8'h00, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b0);
`ifdef LOGIC_ROUND_ROBIN_EN
      check_val("rotation", grant, {1'b1, 3'(i % 8)});
`else
      check_val("rotation", grant, 4'b1000);
`endif
    end

    // A single requester wins from pointer 5 (set up by granting ch4).
    step(8'h00, 1'b1);
    step(8'h10, 1'b0);
    check_val("setup_ptr5", grant, 4'b1100);
    step(8'h02, 1'b0);
    check_val("single_req", grant, 4'b1001);

    // Channels 3 and 6 held for three cycles (the pointer is now 2).
    for (int i = 0; i < 3; i++) begin
      step(8'h48, 1'b0);
`ifdef LOGIC_ROUND_ROBIN_EN
      check_val("hold_3_6", grant, (i == 1) ? 4'b1110 : 4'b1011);
`else
      check_val("hold_3_6", grant, 4'b1011);
`endif
    end

    // A dropped request loses the grant at the next edge.
    step(8'h00, 1'b0);
    check_val("drop", grant, 4'b0000);

    // Randomized requests, dense or sparse, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: rq = 8'($urandom);
        1: rq = 8'($urandom) & 8'($urandom);
        2: rq = 8'(1 << $urandom_range(0, 7));
        default: rq = 8'($urandom) | 8'($urandom);
      endcase
      step(rq, ($urandom_range(0, 24) == 0));
      check_val("random", grant, m_grant);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
